// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
// Bundles the controller's view of the datapath: instruction fields and the
// ALU zero flag come in, mux selects / write enables / ALU control go out.
//   master : the control unit (drives selects and enables)
//   slave  : the datapath (drives op, funct, zero)
interface mips_multicycle_ctrl_if #(
    parameter int OP_WIDTH       = 6,
    parameter int FUNCT_WIDTH    = 6,
    parameter int ALU_CTRL_WIDTH = 3
);
    logic [OP_WIDTH-1:0]       op;
    logic [FUNCT_WIDTH-1:0]    funct;
    logic                      zero;
    logic                      pc_en;
    logic                      iord;
    logic                      mem_write;
    logic                      ir_write;
    logic                      reg_dst;
    logic                      mem_to_reg;
    logic                      reg_write;
    logic                      alu_src_a;
    logic [1:0]                alu_src_b;
    logic [1:0]                pc_src;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    logic                      instr_done;
    logic                      illegal_op;

    modport master (
        input  op, funct, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl,
               instr_done, illegal_op
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl,
               instr_done, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control unit of the multi-cycle MIPS core: a Moore FSM stepping each
// instruction through fetch/decode/execute/memory/writeback, plus the ALU
// decoder.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset (state forced to FETCH)
//   bus   : master side of mips_multicycle_ctrl_if (op/funct/zero in,
//           datapath selects, write enables, alu_ctrl, status pulses out)
module mips_multicycle_ctrl #(
    parameter int OP_WIDTH       = 6,
    parameter int FUNCT_WIDTH    = 6,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_ctrl_if.master  bus
);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b010);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b110);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b001);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b111);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
    } state_t;

    // Encoding 00 doubles as the "unlisted" value, so idle states add.
    typedef enum logic [1:0] {AO_ADD = 2'b00, AO_SUB = 2'b01, AO_FUNCT = 2'b10} aluop_t;

    state_t state;
    logic   op_legal;

    assign op_legal = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_RTYPE) ||
                      (bus.op == OP_BEQ) || (bus.op == OP_ADDI) || (bus.op == OP_J);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    state <= S_DECODE;
                S_DECODE: begin
                    if ((bus.op == OP_LW) || (bus.op == OP_SW)) state <= S_MEMADR;
                    else if (bus.op == OP_RTYPE)                state <= S_EXECUTE;
                    else if (bus.op == OP_BEQ)                  state <= S_BRANCH;
                    else if (bus.op == OP_ADDI)                 state <= S_ADDIEXEC;
                    else if (bus.op == OP_J)                    state <= S_JUMP;
                    else                                        state <= S_FETCH;
                end
                S_MEMADR:   state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:    state <= S_MEMWB;
                S_EXECUTE:  state <= S_ALUWB;
                S_ADDIEXEC: state <= S_ADDIWB;
                default:    state <= S_FETCH;  // last states and unused codes
            endcase
        end
    end

    logic   pc_write, branch, ir_wr, mem_wr, reg_wr, done, illegal;
    aluop_t aluop;

    always_comb begin
        pc_write       = 1'b0;
        branch         = 1'b0;
        ir_wr          = 1'b0;
        mem_wr         = 1'b0;
        reg_wr         = 1'b0;
        done           = 1'b0;
        illegal        = 1'b0;
        aluop          = AO_ADD;
        bus.iord       = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_src     = 2'b00;
        case (state)
            S_FETCH: begin
                bus.alu_src_b = 2'b01;
                ir_wr         = 1'b1;
                pc_write      = 1'b1;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                illegal       = !op_legal;
                done          = !op_legal;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                reg_wr         = 1'b1;
                done           = 1'b1;
            end
            S_MEMWR: begin
                bus.iord = 1'b1;
                mem_wr   = 1'b1;
                done     = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                aluop         = AO_FUNCT;
            end
            S_ALUWB: begin
                bus.reg_dst = 1'b1;
                reg_wr      = 1'b1;
                done        = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                aluop         = AO_SUB;
                bus.pc_src    = 2'b01;
                branch        = 1'b1;
                done          = 1'b1;
            end
            S_ADDIEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_wr = 1'b1;
                done   = 1'b1;
            end
            S_JUMP: begin
                bus.pc_src = 2'b10;
                pc_write   = 1'b1;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by rst_n so an asserted reset kills them at once,
    // without waiting for the state register to settle.
    assign bus.pc_en      = rst_n & (pc_write | (branch & bus.zero));
    assign bus.ir_write   = rst_n & ir_wr;
    assign bus.mem_write  = rst_n & mem_wr;
    assign bus.reg_write  = rst_n & reg_wr;
    assign bus.instr_done = rst_n & done;
    assign bus.illegal_op = rst_n & illegal;

    always_comb begin
        bus.alu_ctrl = ALU_ADD;
        case (aluop)
            AO_SUB: bus.alu_ctrl = ALU_SUB;
            AO_FUNCT: begin
                case (bus.funct)
                    FUNCT_WIDTH'(6'b100010): bus.alu_ctrl = ALU_SUB;
                    FUNCT_WIDTH'(6'b100100): bus.alu_ctrl = ALU_AND;
                    FUNCT_WIDTH'(6'b100101): bus.alu_ctrl = ALU_OR;
                    FUNCT_WIDTH'(6'b101010): bus.alu_ctrl = ALU_SLT;
                    default:                 bus.alu_ctrl = ALU_ADD;
                endcase
            end
            default: bus.alu_ctrl = ALU_ADD;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Drives directed and random instruction streams into the control unit and
// compares every cycle's outputs with an instruction-level model: expected
// outputs are looked up by instruction class and cycle number.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();
    mips_multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
        logic       instr_done;
        logic       illegal_op;
    } obs_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    int errors = 0;
    int checks = 0;

    function automatic bit legal(input logic [5:0] op);
        return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == J;
    endfunction

    // Cycles from FETCH to the last state of the instruction.
    function automatic int latency(input logic [5:0] op);
        if (op == LW) return 5;
        if (op == SW || op == RT || op == ADDI) return 4;
        if (op == BEQ || op == J) return 3;
        return 2;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // alu_ctrl only matters where the step actually uses the ALU.
    function automatic bit alu_used(input logic [5:0] op, input int k);
        if (k <= 1) return 1'b1;
        return (k == 2) && (op == LW || op == SW || op == RT || op == BEQ || op == ADDI);
    endfunction

    function automatic obs_t reset_exp();
        obs_t e = '0;
        e.alu_src_b = 2'b01;
        e.alu_ctrl  = 3'b010;
        return e;
    endfunction

    function automatic obs_t model(input logic [5:0] op, input logic [5:0] f,
                                   input logic z, input int k);
        obs_t e = '0;
        e.alu_ctrl = 3'b010;
        if (k == 0) begin
            e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_en = 1'b1;
        end else if (k == 1) begin
            e.alu_src_b = 2'b11;
            if (!legal(op)) begin e.illegal_op = 1'b1; e.instr_done = 1'b1; end
        end else if (op == LW || op == SW) begin
            if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            else if (k == 3 && op == LW) e.iord = 1'b1;
            else if (k == 3) begin e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = 1'b1; end
            else begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
        end else if (op == RT) begin
            if (k == 2) begin e.alu_src_a = 1'b1; e.alu_ctrl = funct_alu(f); end
            else begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
        end else if (op == BEQ) begin
            e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
            e.pc_en = z; e.instr_done = 1'b1;
        end else if (op == ADDI) begin
            if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            else begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
        end else if (op == J) begin
            e.pc_src = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc_en = bus.pc_en;         o.iord = bus.iord;
        o.mem_write = bus.mem_write; o.ir_write = bus.ir_write;
        o.reg_dst = bus.reg_dst;     o.mem_to_reg = bus.mem_to_reg;
        o.reg_write = bus.reg_write; o.alu_src_a = bus.alu_src_a;
        o.alu_src_b = bus.alu_src_b; o.pc_src = bus.pc_src;
        o.alu_ctrl = bus.alu_ctrl;   o.instr_done = bus.instr_done;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    task automatic chk(input string tag, input obs_t e, input bit use_alu);
        obs_t o = sample();
        if (!use_alu) o.alu_ctrl = e.alu_ctrl;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // zmode: 0/1 force zero, 2 randomizes it every cycle.
    // abort: drop rst_n in the fourth cycle (MEMWR for sw).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input int zmode, input bit abort);
        int n = latency(op);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin bus.op = op; bus.funct = f; end
            bus.zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            chk($sformatf("op=%b funct=%b cyc=%0d", op, f, k),
                model(op, f, bus.zero, k), alu_used(op, k));
            if (abort && k == 3) begin
                #1 rst_n = 1'b0;
                #1 chk("async_abort", reset_exp(), 1'b1);
                @(posedge clk);
                #2 rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] fset [5];
        logic [5:0] op, f;
        fset[0] = 6'b100000; fset[1] = 6'b100010; fset[2] = 6'b100100;
        fset[3] = 6'b100101; fset[4] = 6'b101010;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("reset_hold", reset_exp(), 1'b1);
        @(posedge clk);
        #($urandom_range(1, 3)) rst_n = 1'b1;

        run_instr(LW, 6'b000000, 2, 1'b0);
        run_instr(SW, 6'b000000, 2, 1'b0);
        for (int i = 0; i < 5; i++) run_instr(RT, fset[i], 2, 1'b0);
        run_instr(RT, 6'b111000, 2, 1'b0);
        run_instr(BEQ, 6'b000000, 1, 1'b0);
        run_instr(BEQ, 6'b000000, 0, 1'b0);
        run_instr(J, 6'b000000, 2, 1'b0);
        run_instr(ADDI, 6'b000000, 2, 1'b0);
        run_instr(6'b111111, 6'b000000, 2, 1'b0);
        run_instr(SW, 6'b000000, 2, 1'b1);
        run_instr(LW, 6'b000000, 2, 1'b0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = BEQ;
                4: op = ADDI;
                5: op = J;
                default: begin
                    op = 6'($urandom);
                    while (legal(op)) op = 6'($urandom);
                end
            endcase
            f = ($urandom_range(0, 1) == 0) ? fset[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(op, f, 2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
